// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   arb_state_e : arbiter FSM state encodings
//   arb_req_e   : requester identity (used by the round-robin tie-break)
//   STOP/NO_STOP: stall request levels driven towards CTRL
//   stall_of    : stall request for one requester
package sram_port_arbiter_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_e;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // A stage stalls while its request is outstanding and not completing this cycle.
    function automatic logic stall_of(input logic req, input logic valid);
        return (req && !valid) ? STOP : NO_STOP;
    endfunction

endpackage

// File: rtl/sram_arb_wait_cnt.sv
// Wait counter for one SRAM access: counts grant cycles without sram_ready.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : restart the count (no access waiting)
//   inc        : one more cycle waited
//   expired_c  : this wait cycle is the MAX_WAIT-th one; the access is abandoned
module sram_arb_wait_cnt
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired_c
);

    logic [WAIT_CNT_W-1:0] cnt;

    assign expired_c = inc && (cnt == WAIT_CNT_W'(MAX_WAIT - 1));

    // Count waited cycles; restart on clear or when the limit is hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || expired_c) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WAIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch (IF) and data access (MEM).
// Data requests win over fetches (older instruction); one access at a time, no preemption.
// Optional build macro SRAM_ARB_RR_EN: simultaneous requests alternate between I and D.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   inst_req/inst_addr               : IF read request
//   data_req/data_wen/addr/wdata     : MEM load (wen=0) or store request
//   sram_en/wen/addr/wdata           : registered SRAM request, stable until sram_ready
//   sram_rdata/sram_ready            : SRAM response
//   inst_rdata/inst_valid            : fetch result, one-cycle completion pulse
//   data_rdata/data_valid            : load result (unchanged by stores), completion pulse
//   stallreq_if/stallreq_mem         : stall requests to CTRL while an access is pending
//   timeout_err                      : sticky; an access was abandoned after MAX_WAIT cycles
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    input  logic                sram_ready,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_valid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_valid,
    output logic                stallreq_if,
    output logic                stallreq_mem,
    output logic                timeout_err
);

    arb_state_e          state, state_d;
    logic                sram_en_d;
    logic [DATA_W/8-1:0] sram_wen_d;
    logic [ADDR_W-1:0]   sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_d;
    logic [DATA_W-1:0]   inst_rdata_d, data_rdata_d;
    logic                inst_valid_d, data_valid_d, timeout_err_d;
    logic                pick_i, pick_d;
    logic                in_gnt, wait_expired_c;
`ifdef SRAM_ARB_RR_EN
    arb_req_e            last_grant, last_grant_d;
`endif

    assign in_gnt = (state == ARB_GNT_I) || (state == ARB_GNT_D);

    sram_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (!in_gnt || sram_ready),
        .inc       (in_gnt && !sram_ready),
        .expired_c (wait_expired_c)
    );

    assign stallreq_if  = stall_of(inst_req, inst_valid);
    assign stallreq_mem = stall_of(data_req, data_valid);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            sram_en     <= 1'b0;
            sram_wen    <= '0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            inst_rdata  <= '0;
            data_rdata  <= '0;
            inst_valid  <= 1'b0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_grant  <= REQ_I;
`endif
        end else begin
            state       <= state_d;
            sram_en     <= sram_en_d;
            sram_wen    <= sram_wen_d;
            sram_addr   <= sram_addr_d;
            sram_wdata  <= sram_wdata_d;
            inst_rdata  <= inst_rdata_d;
            data_rdata  <= data_rdata_d;
            inst_valid  <= inst_valid_d;
            data_valid  <= data_valid_d;
            timeout_err <= timeout_err_d;
`ifdef SRAM_ARB_RR_EN
            last_grant  <= last_grant_d;
`endif
        end
    end

    // Next state and next register values.
    always_comb begin
        state_d       = state;
        sram_en_d     = sram_en;
        sram_wen_d    = sram_wen;
        sram_addr_d   = sram_addr;
        sram_wdata_d  = sram_wdata;
        inst_rdata_d  = inst_rdata;
        data_rdata_d  = data_rdata;
        inst_valid_d  = 1'b0;
        data_valid_d  = 1'b0;
        timeout_err_d = timeout_err;
        pick_i        = 1'b0;
        pick_d        = 1'b0;
`ifdef SRAM_ARB_RR_EN
        last_grant_d  = last_grant;
`endif
        case (state)
            ARB_IDLE: begin
`ifdef SRAM_ARB_RR_EN
                // On a tie, the requester that lost the previous tie goes first.
                if (inst_req && data_req) begin
                    pick_d       = (last_grant == REQ_I);
                    pick_i       = !pick_d;
                    last_grant_d = pick_d ? REQ_D : REQ_I;
                end else begin
                    pick_d = data_req;
                    pick_i = inst_req;
                end
`else
                pick_d = data_req;
                pick_i = inst_req && !data_req;
`endif
                if (pick_d) begin
                    state_d      = ARB_GNT_D;
                    sram_en_d    = 1'b1;
                    sram_wen_d   = data_wen;
                    sram_addr_d  = data_addr;
                    sram_wdata_d = data_wdata;
                end else if (pick_i) begin
                    state_d      = ARB_GNT_I;
                    sram_en_d    = 1'b1;
                    sram_wen_d   = '0;
                    sram_addr_d  = inst_addr;
                    sram_wdata_d = '0;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                // Complete on ready, or abandon with zero data once the wait limit is hit.
                if (sram_ready || wait_expired_c) begin
                    state_d    = ARB_RESP;
                    sram_en_d  = 1'b0;
                    sram_wen_d = '0;
                    if (state == ARB_GNT_I) begin
                        inst_valid_d = 1'b1;
                        inst_rdata_d = sram_ready ? sram_rdata : '0;
                    end else begin
                        data_valid_d = 1'b1;
                        if (!sram_ready) begin
                            data_rdata_d = '0;
                        end else if (sram_wen == '0) begin
                            data_rdata_d = sram_rdata;
                        end
                    end
                    if (!sram_ready) begin
                        timeout_err_d = 1'b1;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sram_port_arbiter;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = 32'h5A5A5A5A;
    logic        sram_ready = 1'b0;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        timeout_err;

    sram_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .data_req     (data_req),
        .data_wen     (data_wen),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .inst_rdata   (inst_rdata),
        .inst_valid   (inst_valid),
        .data_rdata   (data_rdata),
        .data_valid   (data_valid),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    int lat   = 1;      // SRAM answers in the lat-th enabled cycle; 0 = never
    logic [3:0] seen_wen = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h24020001;
            32'h80000010: return 32'h8C420004;
            default:      return a ^ 32'hA5A50000;
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // SRAM responder.
    initial begin : sram_model
        int en_cnt;
        en_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_en === 1'b1) en_cnt++;
            else en_cnt = 0;
            if (sram_en === 1'b1 && lat != 0 && en_cnt >= lat) begin
                sram_ready = 1'b1;
                sram_rdata = mem_rd(sram_addr);
            end else begin
                sram_ready = 1'b0;
                sram_rdata = 32'h5A5A5A5A;
            end
        end
    end

    // Reference model: one access in flight (owner), then one response cycle, then free.
    int          m_owner = 0;   // 0 none, 1 fetch, 2 data
    bit          m_resp  = 1'b0;
    int          m_waits = 0;
    bit          m_tie_d = 1'b0;  // last tie went to data
    logic        e_en = 0, e_iv = 0, e_dv = 0, e_tout = 0;
    logic [31:0] e_addr = 0, e_wdata = 0, e_ird = 0, e_drd = 0;
    logic [3:0]  e_wen = 0;

    task automatic retire(input bit tout);
        e_en    = 1'b0;
        m_resp  = 1'b1;
        m_waits = 0;
        if (m_owner == 1) begin
            e_iv  = 1'b1;
            e_ird = tout ? 32'h0 : sram_rdata;
        end else begin
            e_dv = 1'b1;
            if (tout) e_drd = 32'h0;
            else if (e_wen == 4'h0) e_drd = sram_rdata;
        end
        if (tout) e_tout = 1'b1;
        m_owner = 0;
    endtask

    always @(posedge clk) begin : ref_model
        bit take_d;
        e_iv = 1'b0;
        e_dv = 1'b0;
        if (rst) begin
            m_owner = 0; m_resp = 0; m_waits = 0; m_tie_d = 0;
            e_en = 0; e_addr = 0; e_wen = 0; e_wdata = 0;
            e_ird = 0; e_drd = 0; e_tout = 0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_owner != 0) begin
            if (sram_ready) retire(1'b0);
            else begin
                m_waits++;
                if (m_waits == MAX_WAIT) retire(1'b1);
            end
        end else if (inst_req || data_req) begin
            take_d = data_req;
`ifdef SRAM_ARB_RR_EN
            if (inst_req && data_req) begin
                take_d  = !m_tie_d;
                m_tie_d = take_d;
            end
`endif
            e_en = 1'b1;
            if (take_d) begin
                m_owner = 2; e_addr = data_addr; e_wen = data_wen; e_wdata = data_wdata;
            end else begin
                m_owner = 1; e_addr = inst_addr; e_wen = 4'h0; e_wdata = 32'h0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sram_en", 32'(sram_en), 32'(e_en));
            if (e_en) begin
                chk("sram_addr", sram_addr, e_addr);
                chk("sram_wen", 32'(sram_wen), 32'(e_wen));
                if (e_wen != 4'h0) chk("sram_wdata", sram_wdata, e_wdata);
            end
            chk("inst_valid", 32'(inst_valid), 32'(e_iv));
            chk("data_valid", 32'(data_valid), 32'(e_dv));
            chk("inst_rdata", inst_rdata, e_ird);
            chk("data_rdata", data_rdata, e_drd);
            chk("timeout_err", 32'(timeout_err), 32'(e_tout));
            chk("stallreq_if", 32'(stallreq_if), 32'(inst_req & ~e_iv));
            chk("stallreq_mem", 32'(stallreq_mem), 32'(data_req & ~e_dv));
            if (sram_en === 1'b1) seen_wen = sram_wen;
        end
    end

    // Requesters: called just after a posedge; return cycles from request to valid.
    task automatic do_inst(input logic [31:0] a, output int vcyc, output int stalls);
        int c0;
        bit got;
        inst_addr = a; inst_req = 1'b1;
        c0 = cyc; got = 1'b0; stalls = 0; vcyc = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) begin got = 1'b1; vcyc = cyc - c0; break; end
            if (stallreq_if === 1'b1) stalls++;
        end
        chk("inst_valid_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        inst_req = 1'b0;
    endtask

    task automatic do_data(input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd,
                           output int vcyc, output int stalls);
        int c0;
        bit got;
        data_addr = a; data_wen = w; data_wdata = wd; data_req = 1'b1;
        c0 = cyc; got = 1'b0; stalls = 0; vcyc = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (data_valid === 1'b1) begin got = 1'b1; vcyc = cyc - c0; break; end
            if (stallreq_mem === 1'b1) stalls++;
        end
        chk("data_valid_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        data_req = 1'b0; data_wen = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int vi, vd, si, sd, pulses;

        // 1: reset held for two cycles
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_sram_en", 32'(sram_en), 32'd0);
        chk("rst_sram_addr", sram_addr, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 2: single fetch, minimum latency
        lat = 1;
        do_inst(32'hBFC00000, vi, si);
        chk("fetch_latency", vi, 32'd2);
        chk("fetch_rdata", inst_rdata, 32'h24020001);
        chk("fetch_stall_cycles", si, 32'd2);
        @(negedge clk);
        chk("fetch_stall_after", 32'(stallreq_if), 32'd0);
        idle(2);

        // 3: contention, data first on the first tie
        fork
            do_inst(32'hBFC00000, vi, si);
            do_data(32'h80000010, 4'h0, 32'h0, vd, sd);
        join
        chk("tie1_data_latency", vd, 32'd2);
        chk("tie1_inst_latency", vi, 32'd5);
        chk("tie1_load_rdata", data_rdata, 32'h8C420004);
        idle(2);
        fork
            do_inst(32'hBFC00004, vi, si);
            do_data(32'h80000010, 4'h0, 32'h0, vd, sd);
        join
`ifdef SRAM_ARB_RR_EN
        chk("tie2_inst_latency", vi, 32'd2);
        chk("tie2_data_latency", vd, 32'd5);
`else
        chk("tie2_data_latency", vd, 32'd2);
        chk("tie2_inst_latency", vi, 32'd5);
`endif
        chk("tie2_inst_rdata", inst_rdata, 32'hBFC00004 ^ 32'hA5A50000);
        idle(2);

        // 4: store leaves load data untouched
        lat = 2;
        do_data(32'h80000020, 4'b0011, 32'hDEADBEEF, vd, sd);
        chk("store_latency", vd, 32'd3);
        chk("store_wen", 32'(seen_wen), 32'h3);
        chk("store_rdata_kept", data_rdata, 32'h8C420004);
        idle(2);

        // 5: slow SRAM, ready on the fifth enabled cycle
        lat = 5;
        do_data(32'h80000040, 4'h0, 32'h0, vd, sd);
        chk("slow_latency", vd, 32'd6);
        chk("slow_stall_cycles", sd, 32'd6);
        chk("slow_rdata", data_rdata, 32'h80000040 ^ 32'hA5A50000);
        idle(2);

        // 6a: SRAM never ready -> abandoned after 15 wait cycles
        lat = 0;
        do_inst(32'hBFC00008, vi, si);
        chk("timeout_latency", vi, 32'd16);
        chk("timeout_rdata", inst_rdata, 32'd0);
        chk("timeout_err_set", 32'(timeout_err), 32'd1);
        idle(3);
        @(negedge clk);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // 6b: reset in the middle of a fetch
        @(posedge clk); #1;
        inst_addr = 32'hBFC0000C; inst_req = 1'b1;
        idle(3);
        rst = 1'b1; inst_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_sram_en", 32'(sram_en), 32'd0);
        chk("rst_mid_timeout_err", 32'(timeout_err), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (inst_valid === 1'b1) pulses++;
        end
        chk("rst_mid_no_valid", pulses, 32'd0);

        // Normal operation resumes after the reset
        lat = 1;
        @(posedge clk); #1;
        do_inst(32'hBFC00000, vi, si);
        chk("post_rst_latency", vi, 32'd2);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
